ahb_slave_pipe: RTL and testbench
=================================

# ahb_slave_pipe

Parametrised AHB slave front end for the AHB-to-APB bridge: decodes the bridge address window into NUM_SEL one-hot peripheral selects, buffers posted writes in a FIFO, stalls reads until the APB side responds, and optionally returns AHB ERROR for out-of-window accesses. Sits between the AHB interconnect and the APB controller FSM, replacing plain address/data pipeline registers with a valid/ready request queue.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SEL, 3, number of APB peripherals (1..8)
- BASE, 32'h8000_0000, window base (aligned to REGION_SIZE)
- REGION_SIZE, 32'h0400_0000, bytes per peripheral, power of two
- FIFO_DEPTH, 4, request FIFO entries, power of two, >=2

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  asynchronous, active-high reset (asserted = 1)
- HWRITE  in  1  transfer direction, 1 = write
- HREADYin  in  1  bus ready; address phase sampled only when 1
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HADDR  in  ADDR_W  address
- HWDATA  in  DATA_W  write data (data phase)
- HREADYout  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_W  read data
- req_valid  out  1  FIFO head valid
- req_ready  in  1  APB side consumes head
- req_addr  out  ADDR_W  head address
- req_wdata  out  DATA_W  head write data (0 for reads)
- req_write  out  1  head direction
- req_sel  out  NUM_SEL  head one-hot select
- rsp_valid  in  1  read data returned
- rsp_rdata  in  DATA_W  returned read data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- Accept = HREADYin & HREADYout & HTRANS[1]; BUSY/IDLE never accepted.
- In window: BASE <= HADDR < BASE + NUM_SEL*REGION_SIZE; sel index = (HADDR-BASE) >> log2(REGION_SIZE), one-hot.
- FSM states IDLE, WDATA, RD_WAIT, ERR1, ERR2.
- IDLE: HREADYout=1, HRESP=0. Accepted in-window write -> capture addr/sel, go WDATA. Accepted in-window read -> push read entry when FIFO not full, go RD_WAIT (if full, hold captured read and stay stalled in RD_WAIT with push pending). Accepted out-of-window -> ERR1.
- WDATA: HREADYout = !full. When not full, push {addr_q, HWDATA, write=1, sel_q}; same cycle may accept next address phase and branch as in IDLE; else -> IDLE. Full: hold, no push.
- RD_WAIT: HREADYout = rsp_valid, HRDATA = rsp_rdata that cycle (else HRDATA holds last value). On rsp_valid, new address phase may be accepted.
- ERR1: HREADYout=0, HRESP=1 -> ERR2. ERR2: HREADYout=1, HRESP=1; accepted address phase handled as in IDLE.
- FIFO: push and pop in same cycle legal at any level including full (pop frees slot first only for level accounting, not for HREADYout that cycle); pointers wrap modulo FIFO_DEPTH.
- rsp_valid outside RD_WAIT is ignored.

## Timing
- Reset (HRESETn=1, async): state IDLE, FIFO empty, req_valid=0, req_addr/req_wdata/req_sel/req_write=0, fifo_level=0, HREADYout=1, HRESP=0, HRDATA=0. Reset mid-transfer discards all entries and pending reads.
- Write: address phase at edge N, data at edge N+1, req_valid=1 after edge N+1 (1-cycle latency, zero-wait if not full).
- Read: entry visible after acceptance edge; AHB completes the cycle rsp_valid=1.
- Head outputs registered, stable while req_valid & !req_ready.
- Back-to-back writes sustain one per cycle while not full.

## Configuration
- AHB_ERR_RESP_EN defined: out-of-window accepted transfers get two-cycle ERROR (ERR1, ERR2); nothing pushed.
- Undefined: ERR states removed; out-of-window transfers complete with OKAY, zero wait, nothing pushed, HRDATA=0 for reads; HRESP tied 0.

## Test plan
- Reset: assert HRESETn mid-WDATA with 2 entries queued -> immediately HREADYout=1, req_valid=0, fifo_level=0.
- Write HADDR=32'h8400_0010, HWDATA=32'hDEAD_BEEF, req_ready=1 -> one cycle after data phase req_valid=1, req_sel=3'b010, req_wdata=32'hDEAD_BEEF.
- Five back-to-back writes, req_ready=0, DEPTH=4 -> fifo_level reaches 4, HREADYout=0 during 5th data phase; raise req_ready -> 5th pushed, order preserved.
- Read HADDR=32'h8000_0004 behind 2 queued writes -> read entry third, sel=3'b001; HREADYout=0 until rsp_valid with rsp_rdata=32'h1234_5678 -> HRDATA=32'h1234_5678, HREADYout=1.
- HADDR=32'h9000_0000 NONSEQ, AHB_ERR_RESP_EN defined -> HRESP=1 two cycles, HREADYout 0 then 1, no push; undefined -> OKAY, no push.
- HTRANS=BUSY and HREADYin=0 with in-window address -> no push, state IDLE.

Source files
------------

// File: rtl/ahb_slave_pipe.sv
// AHB slave front end for the AHB-to-APB bridge: window decode, request FIFO, read stall.
// Define AHB_ERR_RESP_EN to return a two-cycle AHB ERROR for out-of-window transfers.
module ahb_slave_pipe #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_SEL     = 3,
    parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] REGION_SIZE = ADDR_W'(32'h0400_0000),
    parameter int unsigned       FIFO_DEPTH  = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        HWRITE,
    input  logic                        HREADYin,
    input  logic [1:0]                  HTRANS,
    input  logic [ADDR_W-1:0]           HADDR,
    input  logic [DATA_W-1:0]           HWDATA,
    output logic                        HREADYout,
    output logic                        HRESP,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [ADDR_W-1:0]           req_addr,
    output logic [DATA_W-1:0]           req_wdata,
    output logic                        req_write,
    output logic [NUM_SEL-1:0]          req_sel,
    input  logic                        rsp_valid,
    input  logic [DATA_W-1:0]           rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW     = PtrW + 1;
    localparam int unsigned RegShift = $clog2(REGION_SIZE);
    localparam logic [ADDR_W:0] WinEnd =
        {1'b0, BASE} + ({1'b0, REGION_SIZE} * (ADDR_W + 1)'(NUM_SEL));

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StRdWait
`ifdef AHB_ERR_RESP_EN
        ,
        StErr1,
        StErr2
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_SEL-1:0]  sel_q, sel_d;
    logic                rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;

    logic                trans_active, in_win, full, take, hready, pop;
    logic [ADDR_W-1:0]   offs, sel_idx;
    logic [NUM_SEL-1:0]  sel_dec;
    logic [DATA_W-1:0]   rdata;

    logic                push, push_write;
    logic [ADDR_W-1:0]   push_addr;
    logic [DATA_W-1:0]   push_wdata;
    logic [NUM_SEL-1:0]  push_sel;

    logic [ADDR_W-1:0]   addr_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0]   wdata_mem [FIFO_DEPTH];
    logic                write_mem [FIFO_DEPTH];
    logic [NUM_SEL-1:0]  sel_mem   [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]     level_q;

`ifdef AHB_ERR_RESP_EN
    logic resp;
`endif

    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign in_win       = ({1'b0, HADDR} >= {1'b0, BASE}) && ({1'b0, HADDR} < WinEnd);
    assign offs         = HADDR - BASE;
    assign sel_idx      = offs >> RegShift;
    assign full         = (level_q == LvlW'(FIFO_DEPTH));
    assign pop          = req_valid && req_ready;

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < int'(NUM_SEL); i++) begin
            sel_dec[i] = (sel_idx == ADDR_W'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        rd_pend_d  = rd_pend_q;
        hrdata_d   = hrdata_q;
        hready     = 1'b1;
        rdata      = hrdata_q;
        take       = 1'b0;
        push       = 1'b0;
        push_addr  = addr_q;
        push_wdata = HWDATA;
        push_write = 1'b1;
        push_sel   = sel_q;
`ifdef AHB_ERR_RESP_EN
        resp       = 1'b0;
`endif
        case (state_q)
            StIdle: take = 1'b1;
            StWdata: begin
                hready = !full;
                if (!full) begin
                    push    = 1'b1;
                    take    = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdWait: begin
                // A read captured while the FIFO was full is pushed before any response counts
                if (rd_pend_q) begin
                    hready = 1'b0;
                    if (!full) begin
                        push       = 1'b1;
                        push_wdata = '0;
                        push_write = 1'b0;
                        rd_pend_d  = 1'b0;
                    end
                end else begin
                    hready = rsp_valid;
                    if (rsp_valid) begin
                        rdata    = rsp_rdata;
                        hrdata_d = rsp_rdata;
                        take     = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
`ifdef AHB_ERR_RESP_EN
            StErr1: begin
                hready  = 1'b0;
                resp    = 1'b1;
                state_d = StErr2;
            end
            StErr2: begin
                resp    = 1'b1;
                take    = 1'b1;
                state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (take && HREADYin && trans_active) begin
            if (in_win) begin
                addr_d = HADDR;
                sel_d  = sel_dec;
                if (HWRITE) begin
                    state_d = StWdata;
                end else begin
                    state_d = StRdWait;
                    // The single push port may already carry the previous write's data
                    if (!push && !full) begin
                        push       = 1'b1;
                        push_addr  = HADDR;
                        push_wdata = '0;
                        push_write = 1'b0;
                        push_sel   = sel_dec;
                    end else begin
                        rd_pend_d = 1'b1;
                    end
                end
            end else begin
`ifdef AHB_ERR_RESP_EN
                state_d = StErr1;
`else
                state_d = StIdle;
                if (!HWRITE) hrdata_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            sel_q     <= '0;
            rd_pend_q <= 1'b0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            rd_pend_q <= rd_pend_d;
            hrdata_q  <= hrdata_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                addr_mem[i]  <= '0;
                wdata_mem[i] <= '0;
                write_mem[i] <= 1'b0;
                sel_mem[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr_q]  <= push_addr;
                wdata_mem[wr_ptr_q] <= push_wdata;
                write_mem[wr_ptr_q] <= push_write;
                sel_mem[wr_ptr_q]   <= push_sel;
                wr_ptr_q            <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q <= level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    assign req_valid  = (level_q != '0);
    assign req_addr   = addr_mem[rd_ptr_q];
    assign req_wdata  = wdata_mem[rd_ptr_q];
    assign req_write  = write_mem[rd_ptr_q];
    assign req_sel    = sel_mem[rd_ptr_q];
    assign fifo_level = level_q;
    assign HREADYout  = hready;
    assign HRDATA     = rdata;
`ifdef AHB_ERR_RESP_EN
    assign HRESP      = resp;
`else
    assign HRESP      = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// Bench for ahb_slave_pipe: directed scenarios, then random AHB/APB traffic
// checked against a transaction-order scoreboard.
module tb_ahb_slave_pipe;

    localparam logic [31:0] Base   = 32'h8000_0000;
    localparam logic [31:0] Region = 32'h0400_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  sel;
    } req_t;

    logic        HCLK = 1'b0;
    logic        HRESETn, HWRITE, HREADYin;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HREADYout, HRESP;
    logic        req_valid, req_ready, req_write, rsp_valid;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_sel, fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    req_t exp_q[$];

    // Random-phase master/APB model state
    logic        dp_valid, dp_write, dp_inwin;
    logic [31:0] dp_wdata, rsp_exp;
    int          dp_cyc;
    logic        apb_owed;
    int          apb_dly;

    ahb_slave_pipe dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HWRITE(HWRITE), .HREADYin(HREADYin),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HREADYout(HREADYout),
        .HRESP(HRESP), .HRDATA(HRDATA), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .req_sel(req_sel), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .fifo_level(fifo_level)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (longint'(a) >= longint'(Base)) &&
               (longint'(a) < longint'(Base) + 3 * longint'(Region));
    endfunction

    function automatic logic [2:0] sel_of(input logic [31:0] a);
        return 3'(1 << ((a - Base) / Region));
    endfunction

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] d, input logic w);
        req_t r;
        r.addr  = a;
        r.wdata = w ? d : 32'h0;
        r.write = w;
        r.sel   = sel_of(a);
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [4];
        edges = '{32'h7FFF_FFFC, 32'h8C00_0000, 32'h8BFF_FFFC, 32'h8000_0000};
        case ($urandom % 8)
            0, 1, 2, 3, 4, 5: return Base + 32'($urandom % 3) * Region + 32'($urandom % 64) * 4;
            6:                return 32'h9000_0000 + 32'($urandom % 64) * 4;
            default:          return edges[$urandom % 4];
        endcase
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Compare the FIFO head against the oldest expected request
    task automatic check_head(input string tag);
        req_t e;
        check({tag, "_has_exp"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_addr"}, 64'(req_addr), 64'(e.addr));
            check({tag, "_wdata"}, 64'(req_wdata), 64'(e.wdata));
            check({tag, "_write"}, 64'(req_write), 64'(e.write));
            check({tag, "_sel"}, 64'(req_sel), 64'(e.sel));
        end
    endtask

    // Pop n entries with req_ready held high, bounded by max_cyc cycles
    task automatic pop_n(input string tag, input int n, input int max_cyc);
        int got = 0;
        for (int c = 0; c < max_cyc && got < n; c++) begin
            #1;
            if (req_valid) begin
                check_head(tag);
                got++;
            end
            tick();
        end
        check({tag, "_count"}, 64'(got), 64'(n));
    endtask

    task automatic addr_phase(input logic w, input logic [31:0] a);
        HTRANS = 2'b10;
        HWRITE = w;
        HADDR  = a;
    endtask

    task automatic new_addr_phase(input bit allow);
        if (!allow || ($urandom % 4) == 0) begin
            HTRANS = ($urandom % 2) ? 2'b00 : 2'b01;
        end else begin
            HTRANS = ($urandom % 2) ? 2'b10 : 2'b11;
        end
        HWRITE = 1'($urandom % 2);
        HADDR  = rand_addr();
    endtask

    // One random-traffic cycle: APB side at negedge, master decisions, then drive after posedge
    task automatic step(input bit allow);
        bit acc;
        @(negedge HCLK);
        rsp_valid = 1'b0;
        if (apb_owed) begin
            if (apb_dly == 0) begin
                rsp_valid = 1'b1;
                rsp_rdata = $urandom;
                rsp_exp   = rsp_rdata;
                apb_owed  = 1'b0;
            end else begin
                apb_dly--;
            end
        end
        req_ready = (($urandom % 3) != 0);
        #1;
        check("lvl_bound", 64'(fifo_level <= 3'd4), 64'd1);
        if (req_valid && req_ready) begin
            if (!req_write) begin
                apb_owed = 1'b1;
                apb_dly  = $urandom % 3;
            end
            check_head("rnd_pop");
        end
        if (dp_valid) begin
            if (dp_inwin && !dp_write) begin
                check("rnd_rd_hready", 64'(HREADYout), 64'(rsp_valid));
                check("rnd_rd_resp", 64'(HRESP), 64'd0);
                if (HREADYout) check("rnd_rd_data", 64'(HRDATA), 64'(rsp_exp));
            end else if (dp_inwin) begin
                check("rnd_wr_resp", 64'(HRESP), 64'd0);
            end else begin
`ifdef AHB_ERR_RESP_EN
                check("rnd_err_phase", 64'({HREADYout, HRESP}), (dp_cyc == 0) ? 64'd1 : 64'd3);
`else
                check("rnd_oow_okay", 64'({HREADYout, HRESP}), 64'd2);
                if (!dp_write) check("rnd_oow_rdata", 64'(HRDATA), 64'd0);
`endif
            end
        end else begin
            check("rnd_idle", 64'({HREADYout, HRESP}), 64'd2);
        end
        HREADYin = dp_valid ? HREADYout : (($urandom % 6) != 0);
        acc = HREADYin && HREADYout && HTRANS[1];
        if (dp_valid) begin
            if (HREADYout) dp_valid = 1'b0;
            else dp_cyc++;
        end
        if (acc) begin
            dp_valid = 1'b1;
            dp_write = HWRITE;
            dp_inwin = in_win(HADDR);
            dp_cyc   = 0;
            dp_wdata = $urandom;
            if (dp_inwin) exp_q.push_back(mk(HADDR, dp_wdata, HWRITE));
        end
        tick();
        HWDATA = (dp_valid && dp_write) ? dp_wdata : $urandom;
        if (acc || !HTRANS[1]) new_addr_phase(allow);
    endtask

    initial begin
        logic [31:0] a [5];
        logic [31:0] d [5];
        int n;

        HRESETn = 1'b1; HWRITE = 1'b0; HREADYin = 1'b1; HTRANS = 2'b00;
        HADDR = '0; HWDATA = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("rst_hready", 64'(HREADYout), 64'd1);
        check("rst_hresp", 64'(HRESP), 64'd0);
        check("rst_hrdata", 64'(HRDATA), 64'd0);
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_head", 64'({req_addr, req_wdata}), 64'd0);
        tick();

        // Single write with APB ready
        req_ready = 1'b1;
        addr_phase(1'b1, 32'h8400_0010);
        tick();
        HTRANS = 2'b00;
        HWDATA = 32'hDEAD_BEEF;
        #1;
        check("wr_dphase_rdy", 64'(HREADYout), 64'd1);
        check("wr_dphase_nov", 64'(req_valid), 64'd0);
        tick();
        check("wr_valid", 64'(req_valid), 64'd1);
        check("wr_sel", 64'(req_sel), 64'd2);
        check("wr_wdata", 64'(req_wdata), 64'hDEAD_BEEF);
        check("wr_addr", 64'(req_addr), 64'h8400_0010);
        check("wr_write", 64'(req_write), 64'd1);
        tick();
        check("wr_popped", 64'(req_valid), 64'd0);

        // Five back-to-back writes into a depth-4 FIFO with APB stalled
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a[i] = Base + 32'(i % 3) * Region + 32'(i * 4);
            d[i] = 32'hA5A5_0000 + 32'(i * 32'h111);
            exp_q.push_back(mk(a[i], d[i], 1'b1));
        end
        for (int i = 0; i < 5; i++) begin
            addr_phase(1'b1, a[i]);
            if (i > 0) HWDATA = d[i-1];
            #1;
            check("b2b_ready", 64'(HREADYout), 64'd1);
            tick();
        end
        HTRANS = 2'b00;
        HWDATA = d[4];
        #1;
        check("b2b_level_full", 64'(fifo_level), 64'd4);
        check("b2b_stall", 64'(HREADYout), 64'd0);
        tick();
        check("b2b_stall_hold", 64'(HREADYout), 64'd0);
        req_ready = 1'b1;
        pop_n("b2b", 5, 12);
        check("b2b_empty", 64'(fifo_level), 64'd0);

        // Read queued behind two writes
        req_ready = 1'b0;
        exp_q.push_back(mk(32'h8400_0000, 32'h1111_1111, 1'b1));
        exp_q.push_back(mk(32'h8800_0008, 32'h2222_2222, 1'b1));
        exp_q.push_back(mk(32'h8000_0004, 32'h0, 1'b0));
        addr_phase(1'b1, 32'h8400_0000);
        tick();
        HWDATA = 32'h1111_1111;
        addr_phase(1'b1, 32'h8800_0008);
        tick();
        HWDATA = 32'h2222_2222;
        HTRANS = 2'b00;
        tick();
        addr_phase(1'b0, 32'h8000_0004);
        #1;
        check("rd_addr_rdy", 64'(HREADYout), 64'd1);
        tick();
        HTRANS = 2'b00;
        #1;
        check("rd_level", 64'(fifo_level), 64'd3);
        check("rd_stall", 64'(HREADYout), 64'd0);
        tick();
        check("rd_stall_hold", 64'(HREADYout), 64'd0);
        req_ready = 1'b1;
        pop_n("rd_q", 3, 12);
        req_ready = 1'b0;
        check("rd_wait_rsp", 64'(HREADYout), 64'd0);
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678;
        #1;
        check("rd_done_rdy", 64'(HREADYout), 64'd1);
        check("rd_done_data", 64'(HRDATA), 64'h1234_5678);
        tick();
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        #1;
        check("rd_hold_data", 64'(HRDATA), 64'h1234_5678);
        check("rd_after_rdy", 64'(HREADYout), 64'd1);

        // Out-of-window read
        addr_phase(1'b0, 32'h9000_0000);
        tick();
        HTRANS = 2'b00;
        #1;
`ifdef AHB_ERR_RESP_EN
        check("err1", 64'({HREADYout, HRESP}), 64'd1);
        tick();
        check("err2", 64'({HREADYout, HRESP}), 64'd3);
        tick();
        check("err_done", 64'({HREADYout, HRESP}), 64'd2);
`else
        check("oow_okay", 64'({HREADYout, HRESP}), 64'd2);
        check("oow_rdata", 64'(HRDATA), 64'd0);
`endif
        check("oow_nopush", 64'({req_valid, fifo_level}), 64'd0);

        // BUSY and HREADYin=0 are never accepted
        HTRANS = 2'b01; HWRITE = 1'b0; HADDR = 32'h8000_0000;
        tick();
        check("busy_ignored", 64'({HREADYout, fifo_level}), 64'h8);
        HTRANS = 2'b10; HREADYin = 1'b0;
        tick();
        HTRANS = 2'b00; HREADYin = 1'b1;
        #1;
        check("nordy_ignored", 64'({HREADYout, fifo_level}), 64'h8);

        // Reset mid-WDATA with two entries queued
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_phase(1'b1, Base + 32'(i) * Region);
            HWDATA = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        check("rst_pre_level", 64'(fifo_level), 64'd2);
        HRESETn = 1'b1;
        #1;
        check("rst_mid_rdy", 64'(HREADYout), 64'd1);
        check("rst_mid_valid", 64'(req_valid), 64'd0);
        check("rst_mid_level", 64'(fifo_level), 64'd0);
        HTRANS = 2'b00;
        #1;
        HRESETn = 1'b0;
        exp_q.delete();

        // Random traffic
        dp_valid = 1'b0; dp_write = 1'b0; dp_inwin = 1'b0; dp_cyc = 0;
        dp_wdata = '0; rsp_exp = '0; apb_owed = 1'b0; apb_dly = 0;
        tick();
        new_addr_phase(1'b1);
        for (int i = 0; i < 1500; i++) step(1'b1);
        n = 0;
        while (n < 400 && (exp_q.size() != 0 || dp_valid || apb_owed || HTRANS[1])) begin
            step(1'b0);
            n++;
        end
        check("drain_done", 64'(exp_q.size() != 0 || dp_valid || apb_owed), 64'd0);
        #1;
        check("drain_level", 64'(fifo_level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
